// File: rtl/rom_arbiter_if.sv
// rom_arbiter_if
// Bundles the two requester ports (instruction fetch and data load) and the
// combinational ROM bus that rom_arbiter multiplexes between them.
//
//   if_*  / mem_*  : request (req/addr/gnt) and response (rvalid/rready/
//                    rdata/err) handshake for each requester
//   HADDR          : address driven to the combinational ROM
//   HWDATA         : write data to the ROM, always zero (read-only ROM)
//   HRDATA         : ROM read data, valid in the same cycle as HADDR
//
// Modports:
//   slave  - the arbiter side
//   master - the requesters plus the ROM model (driven by the environment)
interface rom_arbiter_if;
   logic        if_req;
   logic [63:0] if_addr;
   logic        if_gnt;
   logic        if_rvalid;
   logic        if_rready;
   logic [63:0] if_rdata;
   logic        if_err;

   logic        mem_req;
   logic [63:0] mem_addr;
   logic        mem_gnt;
   logic        mem_rvalid;
   logic        mem_rready;
   logic [63:0] mem_rdata;
   logic        mem_err;

   logic [63:0] HADDR;
   logic [63:0] HWDATA;
   logic [63:0] HRDATA;

   modport slave (
      input  if_req, if_addr, if_rready,
      input  mem_req, mem_addr, mem_rready,
      input  HRDATA,
      output if_gnt, if_rvalid, if_rdata, if_err,
      output mem_gnt, mem_rvalid, mem_rdata, mem_err,
      output HADDR, HWDATA
   );

   modport master (
      output if_req, if_addr, if_rready,
      output mem_req, mem_addr, mem_rready,
      output HRDATA,
      input  if_gnt, if_rvalid, if_rdata, if_err,
      input  mem_gnt, mem_rvalid, mem_rdata, mem_err,
      input  HADDR, HWDATA
   );
endinterface

// File: rtl/rom_arbiter.sv
// rom_arbiter
// Shares one combinational, read-only ROM between an instruction-fetch port
// and a data-load port. One request is granted per cycle (combinational
// gnt); the ROM word is captured into a single response slot on the next
// edge, so rvalid follows gnt by one cycle. Contention is resolved by
// granting the port that was not granted most recently.
//
// Ports:
//   HCLK    - clock, all state updates on the rising edge
//   HRESET  - synchronous, active-high reset
//   bus     - rom_arbiter_if.slave: both requester ports and the ROM bus
//
// Parameters:
//   ROM_SIZE  - byte size of the ROM
//   ROM_START - byte base address of the ROM
//
// Response slot
//   resp_valid | resp_port | meaning
//   0          | -         | slot empty, any request may be granted
//   1          | PORT_IF   | fetch response waiting for if_rready
//   1          | PORT_MEM  | load response waiting for mem_rready
module rom_arbiter #(
   parameter logic [63:0] ROM_SIZE  = 64'd256,
   parameter logic [63:0] ROM_START = 64'h0
) (
   input  logic         HCLK,
   input  logic         HRESET,
   rom_arbiter_if.slave bus
);

   typedef enum logic {
      PORT_IF  = 1'b0,
      PORT_MEM = 1'b1
   } port_t;

   // Highest legal offset of an 8-byte access. A ROM smaller than one word
   // has no legal address at all, so the subtraction is never allowed to wrap.
   localparam logic        ROM_FITS = (ROM_SIZE >= 64'd8);
   localparam logic [63:0] ROM_LAST = ROM_FITS ? (ROM_SIZE - 64'd8) : 64'd0;

   logic        resp_valid;
   port_t       resp_port;
   logic [63:0] resp_data;
   logic        resp_err;
   port_t       last_gnt;
   logic [63:0] haddr_q;

   logic        owner_rready;
   logic        slot_free;
   logic        gnt_if;
   logic        gnt_mem;
   logic        gnt_any;
   port_t       gnt_port;
   logic [63:0] gnt_addr;
   logic        gnt_ok;

   function automatic logic addr_ok(input logic [63:0] addr, input port_t port);
      logic in_range;
      logic aligned;
      in_range = ROM_FITS && (addr >= ROM_START) && ((addr - ROM_START) <= ROM_LAST);
      if (port == PORT_IF)
         aligned = (addr[1:0] == 2'b00);
      else
         aligned = (addr[2:0] == 3'b000);
      return in_range && aligned;
   endfunction

   // A full slot can be refilled in the same cycle its owner drains it, which
   // gives one grant per cycle under continuous demand.
   always_comb begin
      owner_rready = (resp_port == PORT_IF) ? bus.if_rready : bus.mem_rready;
      slot_free    = !resp_valid || owner_rready;

      gnt_if  = 1'b0;
      gnt_mem = 1'b0;
      if (!HRESET && slot_free) begin
         if (bus.if_req && bus.mem_req) begin
            if (last_gnt == PORT_MEM)
               gnt_if = 1'b1;
            else
               gnt_mem = 1'b1;
         end else if (bus.if_req) begin
            gnt_if = 1'b1;
         end else if (bus.mem_req) begin
            gnt_mem = 1'b1;
         end
      end

      gnt_any  = gnt_if || gnt_mem;
      gnt_port = gnt_mem ? PORT_MEM : PORT_IF;
      gnt_addr = gnt_mem ? bus.mem_addr : bus.if_addr;
      gnt_ok   = addr_ok(gnt_addr, gnt_port);
   end

   // Rejected accesses never reach the ROM bus; HADDR keeps the last legal
   // address so the ROM sees no spurious traffic.
   assign bus.HADDR  = (gnt_any && gnt_ok) ? gnt_addr : haddr_q;
   assign bus.HWDATA = 64'h0;

   assign bus.if_gnt  = gnt_if;
   assign bus.mem_gnt = gnt_mem;

   assign bus.if_rvalid  = resp_valid && (resp_port == PORT_IF);
   assign bus.mem_rvalid = resp_valid && (resp_port == PORT_MEM);
   assign bus.if_rdata   = bus.if_rvalid  ? resp_data : 64'h0;
   assign bus.if_err     = bus.if_rvalid  ? resp_err  : 1'b0;
   assign bus.mem_rdata  = bus.mem_rvalid ? resp_data : 64'h0;
   assign bus.mem_err    = bus.mem_rvalid ? resp_err  : 1'b0;

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         resp_valid <= 1'b0;
         resp_port  <= PORT_IF;
         resp_data  <= 64'h0;
         resp_err   <= 1'b0;
         last_gnt   <= PORT_MEM;
         haddr_q    <= 64'h0;
      end else if (gnt_any) begin
         resp_valid <= 1'b1;
         resp_port  <= gnt_port;
         resp_data  <= gnt_ok ? bus.HRDATA : 64'h0;
         resp_err   <= !gnt_ok;
         last_gnt   <= gnt_port;
         if (gnt_ok)
            haddr_q <= gnt_addr;
      end else if (resp_valid && owner_rready) begin
         resp_valid <= 1'b0;
         resp_data  <= 64'h0;
         resp_err   <= 1'b0;
      end
   end

   gnt_onehot: assert property (@(posedge HCLK) !(bus.if_gnt && bus.mem_gnt));
   gnt_if_req: assert property (@(posedge HCLK) bus.if_gnt |-> bus.if_req);
   gnt_mem_req: assert property (@(posedge HCLK) bus.mem_gnt |-> bus.mem_req);
   gnt_in_rst: assert property (@(posedge HCLK) HRESET |-> !(bus.if_gnt || bus.mem_gnt));

endmodule

// File: tb/tb_rom_arbiter.sv
// tb_rom_arbiter
// Directed scenarios followed by randomized traffic; every cycle the DUT's
// grants, responses and ROM address are compared against a transaction-level
// reference model of the arbiter held in this bench.
module tb_rom_arbiter;
   localparam logic [63:0] ROM_SIZE  = 64'd256;
   localparam logic [63:0] ROM_START = 64'h0;

   logic HCLK = 1'b0;
   logic HRESET;
   always #5 HCLK = ~HCLK;

   rom_arbiter_if bus ();

   rom_arbiter #(
      .ROM_SIZE (ROM_SIZE),
      .ROM_START(ROM_START)
   ) dut (
      .HCLK  (HCLK),
      .HRESET(HRESET),
      .bus   (bus)
   );

   logic [7:0] rom [0:255];

   int n_chk  = 0;
   int n_fail = 0;

   // reference model state
   bit          m_valid;
   bit          m_port;      // 0 = IF, 1 = MEM
   logic [63:0] m_data;
   bit          m_err;
   logic [63:0] m_haddr;
   bit          m_last;      // 1 = MEM granted most recently

   // model grants of the last tick, and DUT outputs seen in it
   bit          g_if, g_mem;
   logic        obs_if_gnt, obs_mem_gnt, obs_if_rvalid, obs_mem_rvalid;
   logic [63:0] obs_mem_rdata;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [63:0] rom_bytes(input logic [63:0] off);
      logic [63:0] w;
      int base;
      base = int'(off);
      for (int i = 0; i < 8; i++)
         w[8*i +: 8] = rom[base + i];
      return w;
   endfunction

   // Combinational ROM: out-of-range addresses return a marker pattern.
   always_comb begin
      if (bus.HADDR >= ROM_START && ({1'b0, bus.HADDR - ROM_START} + 65'd8) <= {1'b0, ROM_SIZE})
         bus.HRDATA = rom_bytes(bus.HADDR - ROM_START);
      else
         bus.HRDATA = 64'hA5A5_A5A5_A5A5_A5A5;
   end

   // What a legal/illegal access is supposed to return, from byte arithmetic.
   function automatic void exp_resp(input logic [63:0] addr, input bit is_mem,
                                    output logic [63:0] data, output bit err);
      bit ok;
      ok = (addr >= ROM_START) && (({1'b0, addr - ROM_START} + 65'd8) <= {1'b0, ROM_SIZE});
      ok = ok && (is_mem ? (addr % 8 == 0) : (addr % 4 == 0));
      data = ok ? rom_bytes(addr - ROM_START) : 64'h0;
      err  = !ok;
   endfunction

   task automatic model_reset();
      m_valid = 0;
      m_port  = 0;
      m_data  = 64'h0;
      m_err   = 0;
      m_haddr = 64'h0;
      m_last  = 1;
   endtask

   // One clock: compare at the falling edge, advance the model at the rising
   // edge, return 1 time unit after it.
   task automatic tick();
      bit          slot_free, rv_if, rv_mem;
      logic [63:0] d, a, exp_haddr;
      bit          e;
      @(negedge HCLK);
      slot_free = !m_valid || (m_port ? bus.mem_rready : bus.if_rready);
      g_if  = 0;
      g_mem = 0;
      if (!HRESET && slot_free) begin
         if (bus.if_req && bus.mem_req) begin
            g_if  = m_last;
            g_mem = !m_last;
         end else begin
            g_if  = bus.if_req;
            g_mem = bus.mem_req;
         end
      end
      a = g_mem ? bus.mem_addr : bus.if_addr;
      exp_resp(a, g_mem, d, e);
      exp_haddr = ((g_if || g_mem) && !e) ? a : m_haddr;
      rv_if  = m_valid && !m_port;
      rv_mem = m_valid && m_port;

      obs_if_gnt     = bus.if_gnt;
      obs_mem_gnt    = bus.mem_gnt;
      obs_if_rvalid  = bus.if_rvalid;
      obs_mem_rvalid = bus.mem_rvalid;
      obs_mem_rdata  = bus.mem_rdata;

      check_eq("if_gnt", bus.if_gnt, g_if);
      check_eq("mem_gnt", bus.mem_gnt, g_mem);
      check_eq("if_rvalid", bus.if_rvalid, rv_if);
      check_eq("mem_rvalid", bus.mem_rvalid, rv_mem);
      check_eq("if_rdata", bus.if_rdata, rv_if ? m_data : 64'h0);
      check_eq("if_err", bus.if_err, rv_if ? m_err : 1'b0);
      check_eq("mem_rdata", bus.mem_rdata, rv_mem ? m_data : 64'h0);
      check_eq("mem_err", bus.mem_err, rv_mem ? m_err : 1'b0);
      check_eq("haddr", bus.HADDR, exp_haddr);
      check_eq("hwdata", bus.HWDATA, 64'h0);

      @(posedge HCLK);
      if (HRESET) begin
         model_reset();
      end else if (g_if || g_mem) begin
         m_valid = 1;
         m_port  = g_mem;
         m_data  = d;
         m_err   = e;
         m_last  = g_mem;
         m_haddr = exp_haddr;
      end else if (m_valid && (m_port ? bus.mem_rready : bus.if_rready)) begin
         m_valid = 0;
      end
      #1;
   endtask

   task automatic idle(input int n);
      bus.if_req  = 0;
      bus.mem_req = 0;
      bus.if_rready  = 1;
      bus.mem_rready = 1;
      for (int i = 0; i < n; i++) tick();
   endtask

   function automatic logic [63:0] pick_addr();
      case ($urandom_range(5, 0))
         0: return 64'($urandom_range(31, 0)) * 64'd8;
         1: return 64'($urandom_range(63, 0)) * 64'd4;
         2: return 64'($urandom_range(255, 0));
         3: return ROM_START + ROM_SIZE - 64'($urandom_range(12, 0));
         4: return 64'hFFFF_FFFF_FFFF_FFF8;
         default: return {$urandom, $urandom};
      endcase
   endfunction

   logic [63:0] a36 [3];

   initial begin
      for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
      rom[0] = 8'h93; rom[1] = 8'h00; rom[2] = 8'h00; rom[3] = 8'h04;
      rom[4] = 8'h13; rom[5] = 8'h01; rom[6] = 8'h80; rom[7] = 8'h00;

      bus.if_req = 1; bus.if_addr = 64'h0; bus.if_rready = 1;
      bus.mem_req = 1; bus.mem_addr = 64'h10; bus.mem_rready = 1;
      HRESET = 1;
      repeat (2) @(posedge HCLK);
      #1;
      model_reset();
      check_eq("reset_if_rvalid", bus.if_rvalid, 1'b0);
      check_eq("reset_mem_rvalid", bus.mem_rvalid, 1'b0);
      check_eq("reset_haddr", bus.HADDR, 64'h0);
      tick();                               // gnts must stay low under reset
      HRESET = 0;

      // single fetch from address 0
      bus.mem_req = 0;
      tick();
      check_eq("r033_gnt", obs_if_gnt, 1'b1);
      bus.if_req = 0;
      check_eq("r033_rvalid", bus.if_rvalid, 1'b1);
      check_eq("r033_rdata", bus.if_rdata, 64'h0080011304000093);
      check_eq("r033_err", bus.if_err, 1'b0);
      idle(2);

      // continuous contention after reset alternates, starting with IF
      HRESET = 1;
      bus.if_req = 1; bus.if_addr = 64'h0;
      bus.mem_req = 1; bus.mem_addr = 64'h10;
      tick();
      HRESET = 0;
      for (int k = 0; k < 8; k++) begin
         tick();
         check_eq("r034_order", obs_if_gnt, (k % 2 == 0) ? 1'b1 : 1'b0);
         check_eq("r034_one_rvalid", 64'(obs_if_rvalid) + 64'(obs_mem_rvalid), (k == 0) ? 64'd0 : 64'd1);
      end
      idle(2);

      // load response held for 3 cycles blocks the fetch port
      bus.mem_req = 1; bus.mem_addr = 64'd8; bus.mem_rready = 0;
      tick();
      bus.mem_req = 0;
      bus.if_req = 1; bus.if_addr = 64'h0;
      for (int k = 0; k < 3; k++) begin
         tick();
         check_eq("r035_if_blocked", obs_if_gnt, 1'b0);
         check_eq("r035_mem_rvalid", obs_mem_rvalid, 1'b1);
         check_eq("r035_mem_rdata", obs_mem_rdata, rom_bytes(64'd8));
      end
      bus.mem_rready = 1;
      tick();
      check_eq("r035_if_gnt", obs_if_gnt, 1'b1);
      idle(2);

      // load range/alignment boundaries
      a36[0] = ROM_START + ROM_SIZE - 64'd7;
      a36[1] = 64'd4;
      a36[2] = ROM_SIZE - 64'd8;
      for (int k = 0; k < 3; k++) begin
         bus.mem_req = 1; bus.mem_addr = a36[k];
         tick();
         bus.mem_req = 0;
         check_eq("r036_err", bus.mem_err, (k == 2) ? 1'b0 : 1'b1);
         check_eq("r036_rdata", bus.mem_rdata, (k == 2) ? rom_bytes(ROM_SIZE - 64'd8) : 64'h0);
         idle(1);
      end

      // reset while a response is pending
      bus.if_req = 1; bus.if_addr = 64'h0; bus.if_rready = 0;
      tick();
      bus.if_req = 0;
      HRESET = 1;
      tick();
      HRESET = 0;
      check_eq("r037_dropped", bus.if_rvalid, 1'b0);
      bus.if_rready = 1;
      tick();
      check_eq("r037_still_dropped", obs_if_rvalid, 1'b0);
      bus.if_req = 1; bus.mem_req = 1; bus.mem_addr = 64'h20;
      tick();
      check_eq("r037_if_first", obs_if_gnt, 1'b1);
      idle(2);

      // fetch alignment is 4 bytes
      bus.if_req = 1; bus.if_addr = 64'd2;
      tick();
      bus.if_req = 0;
      check_eq("r038_err2", bus.if_err, 1'b1);
      check_eq("r038_data2", bus.if_rdata, 64'h0);
      idle(1);
      bus.if_req = 1; bus.if_addr = 64'd4;
      tick();
      bus.if_req = 0;
      check_eq("r038_err4", bus.if_err, 1'b0);
      check_eq("r038_data4", bus.if_rdata, rom_bytes(64'd4));
      idle(2);

      // randomized traffic
      for (int c = 0; c < 3000; c++) begin
         tick();
         if (g_if)  bus.if_req  = 0;
         if (g_mem) bus.mem_req = 0;
         if (!bus.if_req && $urandom_range(1, 0) == 1) begin
            bus.if_req = 1; bus.if_addr = pick_addr();
         end
         if (!bus.mem_req && $urandom_range(1, 0) == 1) begin
            bus.mem_req = 1; bus.mem_addr = pick_addr();
         end
         bus.if_rready  = ($urandom_range(3, 0) != 0);
         bus.mem_rready = ($urandom_range(3, 0) != 0);
         HRESET = ($urandom_range(99, 0) == 0);
      end
      HRESET = 0;
      idle(3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/rom_arbiter.md
ROM_ARBITER -- requirements
Module: rom_arbiter

Interface
REQ-001 Parameter ROM_SIZE, default 256, byte size of the shared ROM.
REQ-002 Parameter ROM_START, default 64'h0, byte base address of the ROM.
REQ-003 HCLK  input  1  sole clock; all state updates on rising edge.
REQ-004 HRESET  input  1  reset, synchronous, active-high.
REQ-005 if_req  input  1  instruction-fetch request; held with if_addr stable until if_gnt.
REQ-006 if_addr  input  64  fetch byte address.
REQ-007 if_gnt  output  1  combinational grant to fetch port, this cycle.
REQ-008 if_rvalid  output  1  fetch response valid.
REQ-009 if_rready  input  1  fetch port accepts response.
REQ-010 if_rdata  output  64  fetch response data.
REQ-011 if_err  output  1  fetch response error flag, qualified by if_rvalid.
REQ-012 mem_req, mem_addr[63:0], mem_gnt, mem_rvalid, mem_rready, mem_rdata[63:0], mem_err: data-load port; same directions, widths and meanings as the if_* port.
REQ-013 HADDR  output  64  address to the combinational ROM.
REQ-014 HWDATA  output  64  constant zero; the ROM is read-only.
REQ-015 HRDATA  input  64  ROM read data, valid in the same cycle as HADDR.

Function
REQ-016 One response slot: resp_valid, resp_port (IF/MEM), resp_data[63:0], resp_err.
REQ-017 Grant allowed when slot is empty, or when it is full and the owning port's rready=1 in the same cycle (back-to-back, one grant per cycle).
REQ-018 At most one of if_gnt/mem_gnt is high in any cycle; a gnt is never high without its req.
REQ-019 Arbitration:
- Only one req high: grant it.
- Both req high: grant the port not granted most recently (last_gnt register).
REQ-020 last_gnt updates only on a grant.
REQ-021 Grant cycle:
- HADDR = granted address.
- On the next edge, slot loads resp_valid=1, resp_port=granted port, resp_data and resp_err per REQ-022..024.
- Latency is 1: rvalid rises the cycle after gnt.
REQ-022 Range check: the address is in range iff addr >= ROM_START and (addr - ROM_START) <= ROM_SIZE-8, evaluated in 64-bit arithmetic with no wrap.
REQ-023 Alignment: IF requires addr[1:0]==0; MEM requires addr[2:0]==0.
REQ-024 In range and aligned: resp_data=HRDATA, resp_err=0. Otherwise resp_data=0, resp_err=1, and HADDR keeps its previous value.
REQ-025 Response outputs:
- if_rvalid = resp_valid && resp_port==IF; mem_rvalid likewise for MEM.
- if_rdata/if_err and mem_rdata/mem_err present resp_data/resp_err when that port's rvalid=1, else 0.
REQ-026 rdata and err remain stable while rvalid=1 and rready=0.
REQ-027 Slot clears on rvalid && rready unless a new grant loads it in the same cycle.
REQ-028 rready is ignored when the port's rvalid=0.
REQ-029 With no grant, HADDR holds its last driven value.

Reset
REQ-030 While HRESET=1 at an edge: resp_valid=0, resp_port=IF, resp_data=0, resp_err=0, HADDR=0, last_gnt=MEM (IF wins first contention).
REQ-031 All gnt outputs are 0 during any cycle in which HRESET=1.
REQ-032 Reset mid-transaction discards the pending response; no rvalid is issued for it after reset.

Verification
REQ-033 if_req=1, if_addr=0, rready=1; ROM bytes 0..7 = 93 00 00 04 13 01 80 00 -> if_gnt in cycle N; if_rvalid in N+1 with if_rdata=64'h0080011304000093, if_err=0.
REQ-034 Both ports request continuously after reset, rready=1 -> grants alternate IF, MEM, IF, MEM...; one rvalid per cycle, none dropped.
REQ-035 mem_addr=8, mem_rready=0 for 3 cycles -> mem_rvalid stays high with stable data; if_req is not granted until the cycle mem_rready=1.
REQ-036 mem_addr=ROM_START+ROM_SIZE-7 and mem_addr=4 (misaligned) -> mem_err=1, mem_rdata=0, HADDR unchanged; mem_addr=ROM_SIZE-8 -> mem_err=0.
REQ-037 HRESET asserted in the cycle after a grant, before rready -> rvalid=0 afterwards; first post-reset contention grants IF.
REQ-038 if_addr=2 -> if_err=1 (misaligned); if_addr=4 -> if_err=0 with data from bytes 4..11.
